uinst_sequencer: RTL and testbench
==================================

Name: uinst_sequencer

Overview:
- Sits directly downstream of a tag-gated instruction FIFO (evrf/mfu side); pops one micro-instruction (uinst) at a time.
- Expands each uinst into 1..2^CNTW per-beat datapath commands with an incrementing address.
- Presents the beats to the datapath over a valid/ready handshake.
- Maintains a completed-tag counter, current_tag, that gates the FIFOs of peer blocks.

Parameters:
- DW, 64: uinst width from the FIFO.
- OPW, 4: opcode field width.
- ADDRW, 9: address field width.
- CNTW, 8: beat-count field width; the field holds beats-1.
- NTAGW, 5: tag width.
- uinst layout, LSB first: op[OPW], addr[ADDRW], cnt[CNTW], tag[NTAGW], tag_last[1]. Remaining bits are ignored.
- Elaboration check: OPW+ADDRW+CNTW+NTAGW+1 <= DW.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- fifo_rd_ok  in  1  FIFO head uinst valid and tag-eligible (show-ahead).
- fifo_rd_data  in  DW  FIFO head uinst; valid whenever fifo_rd_ok=1.
- fifo_rd_en  out  1  pop FIFO head; combinational.
- out_valid  out  1  beat command valid.
- out_ready  in  1  datapath accepts beat.
- out_op  out  OPW  opcode of the current beat.
- out_addr  out  ADDRW  address of the current beat.
- out_tag  out  NTAGW  tag of the owning uinst.
- out_last  out  1  final beat of the uinst.
- current_tag  out  NTAGW  count of completed tag groups.
- tag_done  out  1  one-cycle pulse when a tag group completes.
- busy  out  1  sequencer in RUN or out_valid=1.

Behaviour:
- FSM states:
  - IDLE: no uinst loaded.
  - RUN: a uinst is loaded; registers op, addr, tag, tag_last and beat counter rem (CNTW bits).
- Load slot (load_slot):
  - True in IDLE.
  - True in RUN when the beat on the output is the last beat (out_last=1) and out_valid && out_ready.
- fifo_rd_en = fifo_rd_ok && load_slot && !rst. Never asserted otherwise.
- On fifo_rd_en:
  - Latch fields from fifo_rd_data.
  - rem <= cnt; next cycle the state is RUN with out_valid=1.
  - Latency: pop cycle to first beat valid is 1 cycle.
- out_valid=1 in RUN.
  - out_addr = current address.
  - out_last = (rem==0).
  - out_op and out_tag are held constant for the whole uinst.
- Beat accept (out_valid && out_ready):
  - If rem!=0: addr <= addr+1 modulo 2^ADDRW (wraps 2^ADDRW-1 -> 0); rem <= rem-1.
  - If rem==0: the uinst is complete.
    - If fifo_rd_en is asserted in the same cycle, load the next uinst; back-to-back, no bubble.
    - Else go to IDLE and set out_valid=0.
- Stall: with out_valid=1 and out_ready=0, all outputs hold stable and no pop occurs.
- cnt=0 gives exactly 1 beat with out_last=1. cnt=2^CNTW-1 gives 2^CNTW beats.
- Tag tracking: when the last beat of a uinst with tag_last=1 is accepted:
  - current_tag <= current_tag+1; wraps modulo 2^NTAGW.
  - tag_done=1 for exactly that following cycle.
- out_tag is passed through unchanged; no tag checking is done.
- fifo_rd_ok low while in IDLE: remain in IDLE, out_valid=0, no pop.
- fifo_rd_ok is ignored while in RUN unless load_slot is true.
- Reset values (apply in any state, mid-uinst included; the in-flight uinst is discarded):
  - state=IDLE, out_valid=0, out_op=0, out_addr=0, out_tag=0, out_last=0.
  - current_tag=0, tag_done=0, busy=0, fifo_rd_en=0.
- Reset is not a handshake: during reset, beats are not accepted and the FIFO is not popped.

Test Plan:
- Single beat:
  - Stimulus: after reset, FIFO presents op=3, addr=10, cnt=0, tag=0, tag_last=1; out_ready=1.
  - Required: fifo_rd_en for 1 cycle; next cycle one beat with out_addr=10, out_last=1.
  - Following cycle: current_tag=1, tag_done pulse.
- Multi-beat with stall:
  - Stimulus: cnt=3, addr=100; out_ready low on the 2nd beat for 2 cycles.
  - Required: addresses 100,101,101,101,102,103; out_last only on 103; no pop during the uinst.
- Back-to-back:
  - Stimulus: two queued uinsts, cnt=1 each, fifo_rd_ok constantly 1.
  - Required: 4 consecutive valid beats with no bubble; second pop coincides with accept of beat 2.
- Address wrap and max count:
  - Stimulus: addr=510, cnt=3, ADDRW=9.
  - Required: addresses 510,511,0,1.
  - Also: cnt=255 produces exactly 256 beats.
- Tag grouping:
  - Stimulus: three uinsts with tag_last=0,0,1.
  - Required: current_tag unchanged until the last beat of the third uinst, then increments once.
  - Also: 32 tag groups wrap current_tag 31->0.
- Reset mid-uinst:
  - Stimulus: assert rst during beat 2 of a 5-beat uinst.
  - Required: next cycle out_valid=0, state IDLE, current_tag=0.
  - After reset release, the next FIFO entry is popped normally.

Source files
------------

// File: rtl/uinst_sequencer.sv
`timescale 1ns/1ps
// Expands micro-instructions popped from a tag-gated FIFO into per-beat datapath commands.
// Latency: one cycle from FIFO pop to first beat valid; consecutive uinsts issue with no bubble.
// Backpressure: out_ready low holds the current beat stable and blocks further FIFO pops.
module uinst_sequencer #(
  parameter int DW    = 64,
  parameter int OPW   = 4,
  parameter int ADDRW = 9,
  parameter int CNTW  = 8,
  parameter int NTAGW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_rd_ok,
  input  logic [DW-1:0]    fifo_rd_data,
  output logic             fifo_rd_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OPW-1:0]   out_op,
  output logic [ADDRW-1:0] out_addr,
  output logic [NTAGW-1:0] out_tag,
  output logic             out_last,
  output logic [NTAGW-1:0] current_tag,
  output logic             tag_done,
  output logic             busy
);

  // Number of low bits of a FIFO word that carry uinst fields; the rest are don't-care.
  localparam int LAYOUTW = OPW + ADDRW + CNTW + NTAGW + 1;

  // uinst field layout, MSB first in the declaration so op lands at bit 0.
  typedef struct packed {
    logic             tag_last;
    logic [NTAGW-1:0] tag;
    logic [CNTW-1:0]  cnt;
    logic [ADDRW-1:0] addr;
    logic [OPW-1:0]   op;
  } uinst_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state;
  logic [CNTW-1:0] rem;         // beats remaining after the one on the output
  logic            tag_last_q;  // loaded uinst closes a tag group
  uinst_t          head;
  logic            beat_acc;
  logic            load_slot;

  generate
    if (LAYOUTW > DW) begin : g_layout_check
      $error("uinst_sequencer: uinst fields do not fit in DW");
    end
    if (DW > LAYOUTW) begin : g_spare_bits
      // Upper FIFO word bits carry nothing for this block.
      logic unused_spare;
      assign unused_spare = ^fifo_rd_data[DW-1:LAYOUTW];
    end
  endgenerate

  assign head = fifo_rd_data[LAYOUTW-1:0];

  // Reset is not a handshake: no beat is consumed while rst is high.
  assign beat_acc = out_valid && out_ready && !rst;

  // A new uinst may enter when nothing is loaded or the final beat is leaving this cycle.
  assign load_slot = (state == IDLE) || (beat_acc && out_last);

  // Pop only into a free slot, and never during reset.
  assign fifo_rd_en = fifo_rd_ok && load_slot && !rst;

  assign busy = (state == RUN) || out_valid;

  // Sequencer FSM: load uinsts, step address/beat counter on accept, and count completed tag groups.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      out_valid   <= 1'b0;
      out_op      <= '0;
      out_addr    <= '0;
      out_tag     <= '0;
      out_last    <= 1'b0;
      rem         <= '0;
      tag_last_q  <= 1'b0;
      current_tag <= '0;
      tag_done    <= 1'b0;
    end else begin
      tag_done <= 1'b0;

      // The final beat of a group-closing uinst retires one tag group.
      if (beat_acc && out_last && tag_last_q) begin
        current_tag <= current_tag + 1'b1;
        tag_done    <= 1'b1;
      end

      if (fifo_rd_en) begin
        // Load takes priority: covers both IDLE and the back-to-back case on the last beat.
        state      <= RUN;
        out_valid  <= 1'b1;
        out_op     <= head.op;
        out_addr   <= head.addr;
        out_tag    <= head.tag;
        out_last   <= (head.cnt == '0);
        rem        <= head.cnt;
        tag_last_q <= head.tag_last;
      end else if (beat_acc) begin
        if (!out_last) begin
          // Address wraps naturally at the field width.
          out_addr <= out_addr + 1'b1;
          rem      <= rem - 1'b1;
          out_last <= (rem == CNTW'(1));
        end else begin
          state     <= IDLE;
          out_valid <= 1'b0;
          out_last  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uinst_sequencer.sv
`timescale 1ns/1ps
module tb_uinst_sequencer;

  localparam int DW    = 64;
  localparam int OPW   = 4;
  localparam int ADDRW = 9;
  localparam int CNTW  = 8;
  localparam int NTAGW = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             fifo_rd_ok;
  logic [DW-1:0]    fifo_rd_data;
  logic             fifo_rd_en;
  logic             out_valid;
  logic             out_ready;
  logic [OPW-1:0]   out_op;
  logic [ADDRW-1:0] out_addr;
  logic [NTAGW-1:0] out_tag;
  logic             out_last;
  logic [NTAGW-1:0] current_tag;
  logic             tag_done;
  logic             busy;

  always #5 clk = ~clk;

  uinst_sequencer #(
    .DW(DW), .OPW(OPW), .ADDRW(ADDRW), .CNTW(CNTW), .NTAGW(NTAGW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fifo_rd_ok(fifo_rd_ok),
    .fifo_rd_data(fifo_rd_data),
    .fifo_rd_en(fifo_rd_en),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_op(out_op),
    .out_addr(out_addr),
    .out_tag(out_tag),
    .out_last(out_last),
    .current_tag(current_tag),
    .tag_done(tag_done),
    .busy(busy)
  );

  typedef struct {
    logic [OPW-1:0]   op;
    logic [ADDRW-1:0] addr;
    logic [NTAGW-1:0] tag;
    logic             last;
    logic             tl;
    int               uid;
  } beat_t;

  beat_t         exp_q[$];   // expected beats, pushed when a uinst is queued
  logic [DW-1:0] fifo_q[$];  // FIFO contents seen by the DUT

  int checks   = 0;
  int failures = 0;
  int ncyc     = 0;
  int uid_cnt  = 0;

  logic             chk_on    = 1'b0;
  logic             fifo_gate = 1'b0;
  logic             exp_valid = 1'b0;
  logic             exp_done  = 1'b0;
  logic [NTAGW-1:0] exp_ctag  = '0;

  // Per-cycle samples for scenario-specific checks
  logic             last_rd, last_valid, last_last, last_done, last_acc;
  logic [ADDRW-1:0] last_addr;
  logic [NTAGW-1:0] last_ctag;

  task automatic push_uinst(input logic [OPW-1:0] op, input logic [ADDRW-1:0] addr,
                            input logic [CNTW-1:0] cnt, input logic [NTAGW-1:0] tag,
                            input logic tl);
    logic [DW-1:0]    w;
    logic [ADDRW-1:0] a;
    beat_t            b;
    w = {$urandom, $urandom};
    w[26:0] = {tl, tag, cnt, addr, op};
    fifo_q.push_back(w);
    a = addr;
    for (int i = 0; i <= int'(cnt); i++) begin
      b.op   = op;
      b.addr = a;
      b.tag  = tag;
      b.last = (i == int'(cnt));
      b.tl   = tl;
      b.uid  = uid_cnt;
      exp_q.push_back(b);
      a = a + 1'b1;
    end
    uid_cnt++;
  endtask

  task automatic present();
    if (fifo_gate && fifo_q.size() > 0) begin
      fifo_rd_ok   = 1'b1;
      fifo_rd_data = fifo_q[0];
    end else begin
      fifo_rd_ok   = 1'b0;
      fifo_rd_data = {$urandom, $urandom};
    end
  endtask

  // One clock cycle: present FIFO head, check outputs against the model, advance model, clock.
  task automatic tick();
    logic  exp_rd;
    logic  rd_s;
    beat_t b;
    int    u;
    present();
    #1;
    exp_rd = fifo_rd_ok && !rst &&
             (!exp_valid || (out_ready && exp_q.size() > 0 && exp_q[0].last));
    if (chk_on) begin
      checks++;
      if (fifo_rd_en !== exp_rd) begin
        failures++;
        $display("FAIL rd_en: got %0b expected %0b cycle %0d", fifo_rd_en, exp_rd, ncyc);
      end
      checks++;
      if (out_valid !== exp_valid) begin
        failures++;
        $display("FAIL out_valid: got %0b expected %0b cycle %0d", out_valid, exp_valid, ncyc);
      end
      checks++;
      if (busy !== exp_valid) begin
        failures++;
        $display("FAIL busy: got %0b expected %0b cycle %0d", busy, exp_valid, ncyc);
      end
      checks++;
      if (current_tag !== exp_ctag) begin
        failures++;
        $display("FAIL current_tag: got %0d expected %0d cycle %0d", current_tag, exp_ctag, ncyc);
      end
      checks++;
      if (tag_done !== exp_done) begin
        failures++;
        $display("FAIL tag_done: got %0b expected %0b cycle %0d", tag_done, exp_done, ncyc);
      end
      if (exp_valid && exp_q.size() > 0) begin
        checks++;
        if ({out_op, out_addr, out_tag, out_last} !==
            {exp_q[0].op, exp_q[0].addr, exp_q[0].tag, exp_q[0].last}) begin
          failures++;
          $display("FAIL beat: got op=%0d addr=%0d tag=%0d last=%0b expected op=%0d addr=%0d tag=%0d last=%0b cycle %0d",
                   out_op, out_addr, out_tag, out_last,
                   exp_q[0].op, exp_q[0].addr, exp_q[0].tag, exp_q[0].last, ncyc);
        end
      end
    end
    rd_s       = fifo_rd_en;
    last_rd    = fifo_rd_en;
    last_valid = out_valid;
    last_last  = out_last;
    last_done  = tag_done;
    last_addr  = out_addr;
    last_ctag  = current_tag;
    last_acc   = out_valid && out_ready && !rst;
    if (chk_on) begin
      if (rst) begin
        if (exp_valid && exp_q.size() > 0) begin
          u = exp_q[0].uid;
          while (exp_q.size() > 0 && exp_q[0].uid == u) void'(exp_q.pop_front());
        end
        exp_valid = 1'b0;
        exp_ctag  = '0;
        exp_done  = 1'b0;
      end else begin
        exp_done = 1'b0;
        if (exp_valid && out_ready && exp_q.size() > 0) begin
          b = exp_q.pop_front();
          if (b.last && b.tl) begin
            exp_ctag = exp_ctag + 1'b1;
            exp_done = 1'b1;
          end
          if (b.last) exp_valid = 1'b0;
        end
        if (exp_rd) exp_valid = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (rd_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    ncyc++;
    if (ncyc > 50000) begin
      failures++;
      $display("FAIL watchdog: cycle budget exhausted at %0d", ncyc);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    for (int i = 0; i < n && (exp_q.size() > 0 || exp_valid); i++) tick();
    checks++;
    if (exp_q.size() != 0 || exp_valid) begin
      failures++;
      $display("FAIL drain: %0d beats still expected, valid=%0b", exp_q.size(), exp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; out_ready = 1'b0; fifo_gate = 1'b0;
    tick(); tick(); tick();
    checks++;
    if ({out_valid, out_last, tag_done, busy, fifo_rd_en} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctl: got valid=%0b last=%0b done=%0b busy=%0b rd=%0b expected all 0",
               out_valid, out_last, tag_done, busy, fifo_rd_en);
    end
    checks++;
    if ({out_op, out_addr, out_tag, current_tag} !== 23'd0) begin
      failures++;
      $display("FAIL reset_data: got op=%0d addr=%0d tag=%0d ctag=%0d expected all 0",
               out_op, out_addr, out_tag, current_tag);
    end
    rst = 1'b0;
    chk_on = 1'b1; exp_valid = 1'b0; exp_ctag = '0; exp_done = 1'b0;
  endtask

  task automatic test_single_beat();
    push_uinst(4'd3, 9'd10, 8'd0, 5'd0, 1'b1);
    fifo_gate = 1'b1; out_ready = 1'b1;
    tick();
    checks++;
    if (last_rd !== 1'b1 || last_valid !== 1'b0) begin
      failures++;
      $display("FAIL sb_pop: got rd=%0b valid=%0b expected rd=1 valid=0", last_rd, last_valid);
    end
    tick();
    checks++;
    if (last_valid !== 1'b1 || last_addr !== 9'd10 || last_last !== 1'b1 || last_rd !== 1'b0) begin
      failures++;
      $display("FAIL sb_beat: got valid=%0b addr=%0d last=%0b rd=%0b expected 1 10 1 0",
               last_valid, last_addr, last_last, last_rd);
    end
    tick();
    checks++;
    if (last_valid !== 1'b0 || last_ctag !== 5'd1 || last_done !== 1'b1) begin
      failures++;
      $display("FAIL sb_tag: got valid=%0b ctag=%0d done=%0b expected 0 1 1",
               last_valid, last_ctag, last_done);
    end
    tick();
    checks++;
    if (last_done !== 1'b0) begin
      failures++;
      $display("FAIL sb_done_pulse: got done=%0b expected 0", last_done);
    end
  endtask

  task automatic test_stall();
    logic [ADDRW-1:0] exp_a[6];
    logic             rdy_pat[6];
    exp_a   = '{9'd100, 9'd101, 9'd101, 9'd101, 9'd102, 9'd103};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    push_uinst(4'd5, 9'd100, 8'd3, 5'd7, 1'b0);
    push_uinst(4'd1, 9'd0, 8'd0, 5'd7, 1'b0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (last_rd !== 1'b1) begin
      failures++;
      $display("FAIL st_pop: got rd=%0b expected 1", last_rd);
    end
    for (int i = 0; i < 6; i++) begin
      out_ready = rdy_pat[i];
      tick();
      checks++;
      if (last_valid !== 1'b1 || last_addr !== exp_a[i] ||
          last_last !== (i == 5) || last_rd !== (i == 5)) begin
        failures++;
        $display("FAIL st_beat%0d: got valid=%0b addr=%0d last=%0b rd=%0b expected 1 %0d %0b %0b",
                 i, last_valid, last_addr, last_last, last_rd, exp_a[i], (i == 5), (i == 5));
      end
    end
    drain(20);
  endtask

  task automatic test_back_to_back();
    logic [ADDRW-1:0] exp_a[4];
    logic             exp_rd[4];
    logic             exp_l[4];
    exp_a  = '{9'd20, 9'd21, 9'd40, 9'd41};
    exp_rd = '{1'b0, 1'b1, 1'b0, 1'b0};
    exp_l  = '{1'b0, 1'b1, 1'b0, 1'b1};
    push_uinst(4'd2, 9'd20, 8'd1, 5'd3, 1'b0);
    push_uinst(4'd2, 9'd40, 8'd1, 5'd3, 1'b1);
    out_ready = 1'b1;
    tick();
    checks++;
    if (last_rd !== 1'b1 || last_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_pop: got rd=%0b valid=%0b expected 1 0", last_rd, last_valid);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (last_valid !== 1'b1 || last_addr !== exp_a[i] ||
          last_last !== exp_l[i] || last_rd !== exp_rd[i]) begin
        failures++;
        $display("FAIL b2b_beat%0d: got valid=%0b addr=%0d last=%0b rd=%0b expected 1 %0d %0b %0b",
                 i, last_valid, last_addr, last_last, last_rd, exp_a[i], exp_l[i], exp_rd[i]);
      end
    end
    tick();
    checks++;
    if (last_valid !== 1'b0 || last_rd !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle: got valid=%0b rd=%0b expected 0 0", last_valid, last_rd);
    end
  endtask

  task automatic test_wrap_max();
    logic [ADDRW-1:0] exp_a[4];
    int               beats;
    int               lasts;
    exp_a = '{9'd510, 9'd511, 9'd0, 9'd1};
    push_uinst(4'd4, 9'd510, 8'd3, 5'd9, 1'b0);
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (last_valid !== 1'b1 || last_addr !== exp_a[i] || last_last !== (i == 3)) begin
        failures++;
        $display("FAIL wrap_beat%0d: got valid=%0b addr=%0d last=%0b expected 1 %0d %0b",
                 i, last_valid, last_addr, last_last, exp_a[i], (i == 3));
      end
    end
    push_uinst(4'd6, 9'd0, 8'd255, 5'd9, 1'b1);
    beats = 0; lasts = 0;
    for (int i = 0; i < 2000; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_acc) beats++;
      if (last_acc && last_last) lasts++;
      if (!last_valid && beats > 0) break;
    end
    checks++;
    if (beats != 256 || lasts != 1) begin
      failures++;
      $display("FAIL max_cnt: got beats=%0d lasts=%0d expected 256 1", beats, lasts);
    end
    drain(10);
  endtask

  task automatic test_tag_group();
    logic [NTAGW-1:0] base;
    logic [NTAGW-1:0] prev;
    int               beats, dones, beats_at_done, early;
    logic             wrap_seen;
    base = exp_ctag;
    push_uinst(4'd1, 9'd50, 8'd1, 5'd11, 1'b0);
    push_uinst(4'd1, 9'd60, 8'd1, 5'd11, 1'b0);
    push_uinst(4'd1, 9'd70, 8'd1, 5'd11, 1'b1);
    out_ready = 1'b1;
    beats = 0; dones = 0; beats_at_done = -1; early = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (last_done) begin
        dones++;
        beats_at_done = beats;
      end
      if (dones == 0 && last_ctag !== base) early++;
      if (last_acc) beats++;
    end
    checks++;
    if (dones != 1 || beats_at_done != 6 || early != 0 || last_ctag !== base + 1'b1) begin
      failures++;
      $display("FAIL tag_group: got dones=%0d beats_at_done=%0d early=%0d ctag=%0d expected 1 6 0 %0d",
               dones, beats_at_done, early, last_ctag, base + 1'b1);
    end
    base = exp_ctag;
    for (int i = 0; i < 32; i++) push_uinst(4'd9, 9'(i), 8'd0, 5'(i), 1'b1);
    dones = 0; wrap_seen = 1'b0; prev = base;
    for (int i = 0; i < 200 && dones < 32; i++) begin
      tick();
      if (last_done) dones++;
      if (prev == 5'd31 && last_ctag == 5'd0) wrap_seen = 1'b1;
      prev = last_ctag;
    end
    checks++;
    if (dones != 32 || !wrap_seen || last_ctag !== base) begin
      failures++;
      $display("FAIL tag_wrap: got dones=%0d wrap_seen=%0b ctag=%0d expected 32 1 %0d",
               dones, wrap_seen, last_ctag, base);
    end
    drain(10);
  endtask

  task automatic test_reset_mid();
    push_uinst(4'd7, 9'd200, 8'd4, 5'd2, 1'b1);
    push_uinst(4'd8, 9'd300, 8'd0, 5'd4, 1'b0);
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (last_valid !== 1'b1 || last_addr !== 9'd201 || last_rd !== 1'b0) begin
      failures++;
      $display("FAIL rm_beat2: got valid=%0b addr=%0d rd=%0b expected 1 201 0",
               last_valid, last_addr, last_rd);
    end
    tick();
    checks++;
    if (last_valid !== 1'b0 || last_rd !== 1'b0 || last_ctag !== 5'd0 || last_done !== 1'b0) begin
      failures++;
      $display("FAIL rm_reset: got valid=%0b rd=%0b ctag=%0d done=%0b expected 0 0 0 0",
               last_valid, last_rd, last_ctag, last_done);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (last_rd !== 1'b1 || last_valid !== 1'b0) begin
      failures++;
      $display("FAIL rm_pop: got rd=%0b valid=%0b expected 1 0", last_rd, last_valid);
    end
    tick();
    checks++;
    if (last_valid !== 1'b1 || last_addr !== 9'd300 || last_last !== 1'b1) begin
      failures++;
      $display("FAIL rm_next: got valid=%0b addr=%0d last=%0b expected 1 300 1",
               last_valid, last_addr, last_last);
    end
    drain(10);
  endtask

  initial begin
    fifo_rd_ok   = 1'b0;
    fifo_rd_data = '0;
    out_ready    = 1'b0;
    rst          = 1'b1;
    test_reset();
    test_single_beat();
    test_stall();
    test_back_to_back();
    test_wrap_max();
    test_tag_group();
    test_reset_mid();
    tick();
    checks++;
    if (exp_q.size() != 0 || fifo_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d beats %0d fifo entries expected 0 0", exp_q.size(), fifo_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
